// File: rtl/qvga_fb_pkg.sv
// Shared types and constants for the QVGA frame buffer slice.
package qvga_fb_pkg;

  typedef enum logic [1:0] {LIVE, WAIT_END, FROZEN, WAIT_START} fb_state_e;

  localparam int H_PIX_DEF = 320;
  localparam int V_PIX_DEF = 240;
  localparam int FB_WORDS  = H_PIX_DEF * V_PIX_DEF;
  localparam int FB_LAST   = FB_WORDS - 1;

  // RGB565 fields reduced to RGB444 by keeping the top four bits of each channel
  localparam int RED_HI = 15;
  localparam int RED_LO = 12;
  localparam int GRN_HI = 10;
  localparam int GRN_LO = 7;
  localparam int BLU_HI = 4;
  localparam int BLU_LO = 1;

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] w);
    return {w[RED_HI:RED_LO], w[GRN_HI:GRN_LO], w[BLU_HI:BLU_LO]};
  endfunction

endpackage

// File: rtl/fb_bram_sdp.sv
// Simple dual-port frame store: one write port, one registered read-first read port.
module fb_bram_sdp
  import qvga_fb_pkg::*;
#(
  parameter int DEPTH  = FB_WORDS,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  // Write and read share one edge; the read samples the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/qvga_frame_buffer.sv
// QVGA RGB565 frame store with freeze control and a 3-stage VGA scan-out path.
module qvga_frame_buffer
  import qvga_fb_pkg::*;
#(
  parameter int H_PIX   = 320,
  parameter int V_PIX   = 240,
  parameter int ADDR_W  = 17,
  parameter int UPSCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [15:0]       wData,
  input  logic              freeze,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              display_en,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              frozen,
  output logic              frame_done
);

  localparam int                WORDS   = H_PIX * V_PIX;
  localparam logic [31:0]       WORDS_U = WORDS;
  localparam logic [31:0]       H_U     = H_PIX;
  localparam logic [31:0]       V_U     = V_PIX;
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] H_A     = ADDR_W'(H_PIX);

  fb_state_e         state, stateNext;
  logic              inFrame, isLast, wrEn, bramWe;
  logic              inRange;
  logic [ADDR_W-1:0] rowIdx, colIdx, rdAddrNext;
  logic [ADDR_W-1:0] s1Addr;
  logic              vis1, vis2;
  logic [15:0]       rdWord;
  logic [11:0]       rgbNext;

  assign inFrame = 32'(wAddr) < WORDS_U;
  assign isLast  = (wAddr == LAST_A);
  assign bramWe  = wrEn & ~reset;
  assign frozen  = (state == FROZEN);

  // Freeze state register
  always_ff @(posedge clk) begin
    if (reset) state <= LIVE;
    else       state <= stateNext;
  end

  // Freeze transitions and write permission; only one frame-end write may close the capture
  always_comb begin
    stateNext = state;
    wrEn      = 1'b0;
    case (state)
      LIVE: begin
        wrEn = we & inFrame;
        if (freeze) stateNext = WAIT_END;
      end
      WAIT_END: begin
        wrEn = we & inFrame;
        if (!freeze)              stateNext = LIVE;
        else if (wrEn && isLast)  stateNext = FROZEN;
      end
      FROZEN: begin
        if (!freeze) stateNext = WAIT_START;
      end
      WAIT_START: begin
        if (freeze) stateNext = FROZEN;
        else if (we && wAddr == '0) begin
          wrEn      = 1'b1;
          stateNext = LIVE;
        end
      end
      default: stateNext = LIVE;
    endcase
  end

  // Frame-end pulse, one cycle after the committed last-pixel write
  always_ff @(posedge clk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= wrEn & isLast;
  end

  // VGA coordinate to linear store address; out-of-range coordinates park on address 0
  always_comb begin
    rowIdx     = '0;
    colIdx     = '0;
    inRange    = 1'b0;
    rdAddrNext = '0;
    if (UPSCALE != 0) begin
      inRange = (x_pixel < 10'd640) && (y_pixel < 10'd480);
      rowIdx  = ADDR_W'(y_pixel[9:1]);
      colIdx  = ADDR_W'(x_pixel[9:1]);
    end else begin
      inRange = (32'(x_pixel) < H_U) && (32'(y_pixel) < V_U);
      rowIdx  = ADDR_W'(y_pixel);
      colIdx  = ADDR_W'(x_pixel);
    end
    if (inRange) rdAddrNext = rowIdx * H_A + colIdx;
  end

  // Stages 1 and 2: register the read address, then carry visibility alongside the memory read
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Addr <= '0;
      vis1   <= 1'b0;
      vis2   <= 1'b0;
    end else begin
      s1Addr <= rdAddrNext;
      vis1   <= display_en & inRange;
      vis2   <= vis1;
    end
  end

  fb_bram_sdp #(
    .DEPTH  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .we    (bramWe),
    .waddr (wAddr),
    .wdata (wData),
    .raddr (s1Addr),
    .rdata (rdWord)
  );

  assign rgbNext = vis2 ? rgb565_to_444(rdWord) : 12'h000;

  // Stage 3: registered colour outputs, black outside the visible window
  always_ff @(posedge clk) begin
    if (reset) {red, green, blue} <= 12'h000;
    else       {red, green, blue} <= rgbNext;
  end

endmodule

// File: tb/tb_qvga_frame_buffer.sv
// Directed self-checking bench for qvga_frame_buffer with a read scoreboard queue.
module tb_qvga_frame_buffer;

  localparam int ADDR_W = 17;
  localparam logic [ADDR_W-1:0] LAST = 17'd76799;

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [15:0]       wData;
  logic              freeze;
  logic [9:0]        x_pixel, y_pixel;
  logic              display_en;
  logic [3:0]        red, green, blue;
  logic              frozen, frame_done;

  int assertCount = 0;
  int failCount   = 0;
  logic [11:0] sbQ[$];

  qvga_frame_buffer #(
    .H_PIX(320), .V_PIX(240), .ADDR_W(ADDR_W), .UPSCALE(1)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData),
    .freeze(freeze), .x_pixel(x_pixel), .y_pixel(y_pixel), .display_en(display_en),
    .red(red), .green(green), .blue(blue), .frozen(frozen), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected RGB444 taken straight from the RGB565 bit positions
  function automatic logic [11:0] expRgb(input logic [15:0] w);
    return {w[15:12], w[10:7], w[4:1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; wAddr = a; wData = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Issue one read, optionally colliding a write with the memory-read edge, and check latency
  task automatic readCheck(input string tag, input int x, input int y, input logic en,
                           input logic [11:0] exp, input logic doWr,
                           input logic [ADDR_W-1:0] wa, input logic [15:0] wd);
    logic [11:0] e;
    @(negedge clk);
    x_pixel = 10'(x); y_pixel = 10'(y); display_en = en;
    sbQ.push_back(exp);
    @(negedge clk);
    display_en = 1'b0; x_pixel = '0; y_pixel = '0;
    if (doWr) begin we = 1'b1; wAddr = wa; wData = wd; end
    @(posedge clk); #1;
    we = 1'b0;
    checkOutput({tag, "_early"}, {4'h0, red, green, blue}, 16'h0000);
    @(posedge clk); #1;
    e = sbQ.pop_front();
    checkOutput(tag, {4'h0, red, green, blue}, {4'h0, e});
  endtask

  initial begin
    logic [11:0] e;
    reset = 1'b1; we = 1'b0; wAddr = '0; wData = '0; freeze = 1'b0;
    x_pixel = '0; y_pixel = '0; display_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rgb", {4'h0, red, green, blue}, 16'h0000);
    checkOutput("reset_frozen", {15'h0, frozen}, 16'h0000);
    checkOutput("reset_done", {15'h0, frame_done}, 16'h0000);
    @(negedge clk); reset = 1'b0;

    $display("[TB] basic write and upscaled read");
    applyStimulus(17'd0, 16'hF81F);
    applyStimulus(17'd1, 16'h1234);
    applyStimulus(17'd5, 16'h8421);
    applyStimulus(17'd321, 16'h07E0);
    readCheck("rd_0_0", 0, 0, 1'b1, 12'hF0F, 1'b0, '0, '0);
    readCheck("rd_1_1", 1, 1, 1'b1, 12'hF0F, 1'b0, '0, '0);
    readCheck("rd_2_2", 2, 2, 1'b1, 12'h0F0, 1'b0, '0, '0);
    readCheck("rd_3_3", 3, 3, 1'b1, 12'h0F0, 1'b0, '0, '0);
    readCheck("rd_2_1", 2, 1, 1'b1, expRgb(16'h1234), 1'b0, '0, '0);
    readCheck("rd_blank", 0, 0, 1'b0, 12'h000, 1'b0, '0, '0);
    readCheck("rd_x640", 640, 0, 1'b1, 12'h000, 1'b0, '0, '0);

    $display("[TB] out-of-range and last-pixel writes");
    applyStimulus(17'd76800, 16'hFFFF);
    checkOutput("oor_done", {15'h0, frame_done}, 16'h0000);
    applyStimulus(LAST, 16'hABCD);
    checkOutput("last_done", {15'h0, frame_done}, 16'h0001);
    @(posedge clk); #1;
    checkOutput("last_done_pulse", {15'h0, frame_done}, 16'h0000);
    readCheck("rd_last", 639, 479, 1'b1, expRgb(16'hABCD), 1'b0, '0, '0);
    readCheck("rd_0_after_oor", 0, 0, 1'b1, 12'hF0F, 1'b0, '0, '0);

    $display("[TB] freeze capture");
    @(negedge clk); freeze = 1'b1;
    applyStimulus(17'd100, 16'h1111);
    checkOutput("wait_end_frozen", {15'h0, frozen}, 16'h0000);
    applyStimulus(LAST, 16'h5555);
    checkOutput("freeze_frozen", {15'h0, frozen}, 16'h0001);
    checkOutput("freeze_done", {15'h0, frame_done}, 16'h0001);
    applyStimulus(17'd0, 16'h0000);
    applyStimulus(17'd100, 16'h0000);
    applyStimulus(LAST, 16'h0000);
    checkOutput("frozen_last_done", {15'h0, frame_done}, 16'h0000);
    readCheck("frz_rd_0", 0, 0, 1'b1, 12'hF0F, 1'b0, '0, '0);
    readCheck("frz_rd_100", 200, 0, 1'b1, expRgb(16'h1111), 1'b0, '0, '0);
    readCheck("frz_rd_last", 639, 479, 1'b1, expRgb(16'h5555), 1'b0, '0, '0);

    $display("[TB] resume via wait-start");
    @(negedge clk); freeze = 1'b0;
    @(posedge clk); #1;
    checkOutput("resume_frozen", {15'h0, frozen}, 16'h0000);
    applyStimulus(17'd5, 16'hFFFF);
    readCheck("ws_drop_5", 10, 0, 1'b1, expRgb(16'h8421), 1'b0, '0, '0);
    applyStimulus(17'd0, 16'h07E0);
    applyStimulus(17'd5, 16'h0AAA);
    readCheck("live_rd_5", 10, 0, 1'b1, expRgb(16'h0AAA), 1'b0, '0, '0);
    readCheck("live_rd_0", 0, 0, 1'b1, 12'h0F0, 1'b0, '0, '0);

    $display("[TB] read-first collision");
    applyStimulus(17'd10, 16'hF800);
    readCheck("collide_old", 20, 0, 1'b1, 12'hF00, 1'b1, 17'd10, 16'h001F);
    readCheck("collide_new", 20, 0, 1'b1, 12'h00F, 1'b0, '0, '0);

    $display("[TB] reset mid-stream");
    @(negedge clk); freeze = 1'b1;
    applyStimulus(LAST, 16'h5555);
    checkOutput("pre_rst_frozen", {15'h0, frozen}, 16'h0001);
    @(negedge clk);
    x_pixel = '0; y_pixel = '0; display_en = 1'b1;
    we = 1'b1; wAddr = 17'd0; wData = 16'hFFFF;
    sbQ.push_back(12'h0F0);
    repeat (4) @(posedge clk);
    #1;
    e = sbQ.pop_front();
    checkOutput("stream_rgb", {4'h0, red, green, blue}, {4'h0, e});
    @(negedge clk); reset = 1'b1; freeze = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
    checkOutput("rst_frozen", {15'h0, frozen}, 16'h0000);
    @(negedge clk); reset = 1'b0;
    sbQ.push_back(12'h0F0);
    @(posedge clk); #1;
    checkOutput("flush_1", {4'h0, red, green, blue}, 16'h0000);
    @(posedge clk); #1;
    checkOutput("flush_2", {4'h0, red, green, blue}, 16'h0000);
    @(posedge clk); #1;
    e = sbQ.pop_front();
    checkOutput("flush_3", {4'h0, red, green, blue}, {4'h0, e});
    @(negedge clk); display_en = 1'b0;
    applyStimulus(17'd5, 16'h0555);
    checkOutput("post_rst_frozen", {15'h0, frozen}, 16'h0000);
    readCheck("post_rst_rd_5", 10, 0, 1'b1, expRgb(16'h0555), 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
